inst_seq: RTL and testbench
===========================

Name: inst_seq

Overview:
- Per-PE instruction sequencer directly upstream of the PE data memory.
- Buffers a short program in a local instruction memory, then replays it on start.
- Drives the data-memory control bundle: inst_v/inst (read and destination addresses), rden, wben, shift_v.
- Inserts the write-back delay so wben lines up with the ALU result; pulses done once the last write-back has retired.

Parameters:
INST_WIDTH, 32, instruction width; fields fixed below
IM_DEPTH, 64, instruction memory entries (power of 2)
IM_ADDR_WIDTH, 6, log2(IM_DEPTH)
WB_LAT, 5, cycles from inst_v to wben for write-back instructions (read 1 + BRAM reg 1 + ALU 3)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
im_we  in  1  load strobe: write im_wdata at load pointer
im_wdata  in  INST_WIDTH  instruction to load
im_full  out  1  load pointer has reached IM_DEPTH
start  in  1  single-cycle pulse: run the loaded program
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the final write-back
inst_v  out  1  instruction valid to data memory
inst  out  INST_WIDTH  [31:24] opcode, [23:16] src2, [15:8] src1, [7:0] dst
rden  out  1  data-memory read enable
wben  out  1  write-back enable
shift_v  out  1  shift-read strobe

Behaviour:
- Reset: all outputs 0, FSM IDLE, load pointer 0, pc 0, write-back delay line cleared. Reset mid-run aborts immediately; no further wben is issued.
- Load:
  - im_we in IDLE with load pointer < IM_DEPTH: write the entry and increment the pointer.
  - im_full = (pointer == IM_DEPTH).
  - im_we while full or while not IDLE is ignored.
  - The pointer is the program length and clears only on rst.
- Opcodes:
  - 0x00 NOP: inst_v only.
  - 0x01 RD: inst_v, then rden next cycle.
  - 0x02 ALU: as RD, plus wben WB_LAT cycles after inst_v.
  - 0x03 SHIFT: no inst_v; shift_v held for dst+1 cycles, issue stalled meanwhile.
  - 0xFF END: terminates early.
  - Any other opcode is treated as NOP.
- FSM:
  - IDLE: start with length>0 → FETCH. start with length==0 → done pulse, stay IDLE.
  - FETCH: one cycle, synchronous IM read of im[pc] → ISSUE.
  - ISSUE: present the instruction for one cycle, pc++. SHIFT → SHIFTING. Last entry or END → DRAIN. Otherwise → FETCH. Sustained rate: one instruction per 2 cycles.
  - SHIFTING: down-counter. At 0 → FETCH, or DRAIN if it was the last entry.
  - DRAIN: wait until the WB_LAT-deep write-back shift register is empty, then done=1 for one cycle → IDLE; pc resets to 0.
- inst holds the last issued value when inst_v=0. rden is the registered copy of inst_v for RD/ALU.
- The write-back delay is a WB_LAT-bit shift register fed with (ALU & inst_v); wben is its tail. It never drops or merges pulses.
- start while busy is ignored. start and im_we in the same IDLE cycle: the load is accepted first, so the run includes the new entry.

Optional Feature:
- Macro: INST_SEQ_LOOP_EN.
- Defined:
  - Adds input loop_cnt [7:0], sampled at start.
  - The program is replayed loop_cnt+1 times: after the last entry (or END), pc returns to 0 and FETCH resumes without DRAIN.
  - DRAIN and done occur only after the final pass.
  - loop_cnt=0 behaves exactly as the undefined build.
- Undefined: no loop_cnt port; a single pass per start.

Test Plan:
- Load 3 ALU instrs (dst 0x10, 0x11, 0x12), start → inst_v at cycles 2, 4, 6 after start; rden at 3, 5, 7; wben at 7, 9, 11; done at 12; busy 1..12.
- Load RD, SHIFT dst=3, RD → shift_v high exactly 4 cycles between the two inst_v; rden twice; no wben; done after drain.
- Load 64 entries then im_we once more → im_full=1; the 65th is ignored; a run issues exactly 64 instructions.
- Program [ALU, END, ALU] → exactly one inst_v and one wben; done follows the first wben after drain.
- Assert rst 2 cycles after the first ALU inst_v → all outputs 0 the next cycle; no wben ever appears; a later start with a reloaded program runs clean.
- INST_SEQ_LOOP_EN, loop_cnt=2, program [ALU dst=0x05] → 3 inst_v, 3 wben, a single done pulse after the third wben.

Source files
------------

// File: rtl/inst_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_seq_if
// Description : Bundle between a per-PE instruction sequencer and its
//               neighbours. It carries the program-load path (im_we,
//               im_wdata, im_full), the run control (start, busy, done) and
//               the data-memory control bundle (inst_v, inst, rden, wben,
//               shift_v).
//               master : the sequencer side. It drives im_full, busy, done
//                        and the data-memory controls.
//               slave  : the host / data-memory side.
// Revision    : 1.0  initial release
// ============================================================================
interface inst_seq_if #(
    parameter int INST_WIDTH = 32
);
    logic                  im_we;
    logic [INST_WIDTH-1:0] im_wdata;
    logic                  im_full;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  inst_v;
    logic [INST_WIDTH-1:0] inst;
    logic                  rden;
    logic                  wben;
    logic                  shift_v;

    modport master (
        input  im_we, im_wdata, start,
        output im_full, busy, done, inst_v, inst, rden, wben, shift_v
    );

    modport slave (
        output im_we, im_wdata, start,
        input  im_full, busy, done, inst_v, inst, rden, wben, shift_v
    );
endinterface
`default_nettype wire

// File: rtl/inst_seq.sv
`default_nettype none
// ============================================================================
// Module      : inst_seq
// Description : Per-PE instruction sequencer that sits in front of the PE
//               data memory. A short program is loaded into a local
//               instruction memory and replayed on start. The replay drives
//               the data-memory control bundle. The sequencer delays the
//               write-back enable so that it lines up with the ALU result,
//               and it pulses done once the last write-back has retired.
//
// Ports       : clk      - clock; all logic runs on the rising edge
//               rst      - synchronous active-high reset
//               loop_cnt - extra passes of the program, sampled at start
//                          (present only when INST_SEQ_LOOP_EN is defined)
//               bus      - inst_seq_if.master:
//                            im_we/im_wdata/im_full  program load
//                            start/busy/done         run control
//                            inst_v/inst/rden/wben/shift_v  data memory
//
// Instruction : [31:24] opcode, [23:16] src2, [15:8] src1, [7:0] dst
//               0x00 NOP, 0x01 RD, 0x02 ALU, 0x03 SHIFT, 0xFF END.
//               Every other opcode is issued like a NOP.
//
// Build macro : INST_SEQ_LOOP_EN - when defined, adds the loop_cnt input.
//               The program is then replayed loop_cnt+1 times per start.
//
// Revision    : 1.0  initial release
// ============================================================================
module inst_seq #(
    parameter int INST_WIDTH    = 32,
    parameter int IM_DEPTH      = 64,
    parameter int IM_ADDR_WIDTH = 6,
    parameter int WB_LAT        = 5    // >= 2; read 1 + BRAM reg 1 + ALU 3
) (
    input  wire logic        clk,
    input  wire logic        rst,
`ifdef INST_SEQ_LOOP_EN
    input  wire logic [7:0]  loop_cnt,
`endif
    inst_seq_if.master       bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [7:0] c_OP_RD    = 8'h01;
    localparam logic [7:0] c_OP_ALU   = 8'h02;
    localparam logic [7:0] c_OP_SHIFT = 8'h03;
    localparam logic [7:0] c_OP_END   = 8'hFF;

    // The program length counts from 0 to IM_DEPTH inclusive, so it needs
    // one more bit than a memory address.
    localparam int c_LEN_W = IM_ADDR_WIDTH + 1;
    localparam logic [c_LEN_W-1:0] c_LEN_FULL = c_LEN_W'(IM_DEPTH);

    // This mask covers every write-back stage except the tail. A pulse in
    // the tail is already on wben, so it counts as retired once the tail
    // is the only set bit.
    localparam logic [WB_LAT-1:0] c_WB_BODY = {1'b0, {(WB_LAT-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_ISSUE    = 3'd2,
        S_SHIFTING = 3'd3,
        S_DRAIN    = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                   r_state;
    logic [INST_WIDTH-1:0]    r_im [IM_DEPTH];
    logic [c_LEN_W-1:0]       r_len;        // load pointer == program length
    logic [IM_ADDR_WIDTH-1:0] r_pc;
    logic [7:0]               r_ir_op;      // opcode of the fetched entry
    logic [7:0]               r_ir_dst;     // dst field of the fetched entry
    logic [7:0]               r_shift_cnt;
    logic                     r_shift_last; // the SHIFT was the final entry
    logic [WB_LAT-1:0]        r_wb;         // write-back delay line

    logic                     r_inst_v;
    logic [INST_WIDTH-1:0]    r_inst;
    logic                     r_rden;
    logic                     r_shift_v;
    logic                     r_busy;
    logic                     r_done;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                  w_full;
    logic                  w_load;
    logic                  w_start_ok;
    logic [c_LEN_W-1:0]    w_len_eff;
    logic [INST_WIDTH-1:0] w_im_rdata;
    logic [7:0]            w_rd_op;
    logic                  w_last;
    logic                  w_pass_end;
    logic                  w_loop_more;
    logic [7:0]            w_out_op;
    logic                  w_wb_feed;

    assign w_full     = (r_len == c_LEN_FULL);
    assign w_load     = bus.im_we && (r_state == S_IDLE) && !w_full;
    // The FSM returns to IDLE while busy/done are still high. A start in
    // that cycle belongs to the run that is just ending, so it is ignored.
    assign w_start_ok = bus.start && (r_state == S_IDLE) && !r_busy;
    // A load in the same cycle as start counts toward the program length.
    assign w_len_eff  = r_len + {{(c_LEN_W-1){1'b0}}, w_load};

    assign w_im_rdata = r_im[r_pc];
    assign w_rd_op    = w_im_rdata[31:24];

    // r_pc still points at the entry that is being issued.
    assign w_last     = (({1'b0, r_pc} + c_LEN_W'(1)) == r_len);

    // A pass ends on a non-SHIFT entry that is the last entry or an END.
    // It also ends when a SHIFT that was the last entry finishes counting.
    assign w_pass_end = ((r_state == S_ISSUE) && (r_ir_op != c_OP_SHIFT) &&
                         (w_last || (r_ir_op == c_OP_END))) ||
                        ((r_state == S_SHIFTING) && (r_shift_cnt == 8'd0) &&
                         r_shift_last);

    // The data-memory side of the bundle is derived from the presented
    // instruction. The derivation does not depend on the FSM state.
    assign w_out_op   = r_inst[31:24];
    assign w_wb_feed  = r_inst_v && (w_out_op == c_OP_ALU);

    // ------------------------------------------------------------------
    // Optional multi-pass replay
    // ------------------------------------------------------------------
`ifdef INST_SEQ_LOOP_EN
    logic [7:0] r_loop_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_loop_rem <= 8'd0;
        end else if (w_start_ok) begin
            r_loop_rem <= loop_cnt;
        end else if (w_pass_end && (r_loop_rem != 8'd0)) begin
            r_loop_rem <= r_loop_rem - 8'd1;
        end
    end

    assign w_loop_more = (r_loop_rem != 8'd0);
`else
    assign w_loop_more = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Instruction memory (write port only; it holds no reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_im[r_len[IM_ADDR_WIDTH-1:0]] <= bus.im_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_pc         <= '0;
            r_ir_op      <= 8'd0;
            r_ir_dst     <= 8'd0;
            r_shift_cnt  <= 8'd0;
            r_shift_last <= 1'b0;
            r_wb         <= '0;
            r_inst_v     <= 1'b0;
            r_inst       <= '0;
            r_rden       <= 1'b0;
            r_shift_v    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            // rden follows inst_v by one cycle for the opcodes that read.
            // The write-back delay line shifts every cycle, so pulses
            // move through it in lock-step and are never merged.
            r_rden   <= r_inst_v && ((w_out_op == c_OP_RD) ||
                                     (w_out_op == c_OP_ALU));
            r_wb     <= {r_wb[WB_LAT-2:0], w_wb_feed};
            r_inst_v <= 1'b0;
            r_done   <= 1'b0;

            if (w_load) begin
                r_len <= r_len + c_LEN_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    r_pc   <= '0;
                    if (w_start_ok) begin
                        if (w_len_eff == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                end

                S_FETCH: begin
                    // The IM read is registered straight into the output
                    // stage, so the instruction is presented during ISSUE.
                    // SHIFT and END are not issued, and inst keeps the
                    // value it had before.
                    r_ir_op  <= w_rd_op;
                    r_ir_dst <= w_im_rdata[7:0];
                    if ((w_rd_op != c_OP_SHIFT) && (w_rd_op != c_OP_END)) begin
                        r_inst_v <= 1'b1;
                        r_inst   <= w_im_rdata;
                    end
                    r_state <= S_ISSUE;
                end

                S_ISSUE: begin
                    r_pc <= r_pc + 1'b1;
                    if (r_ir_op == c_OP_SHIFT) begin
                        // shift_v stays high while the count runs from dst
                        // down to 0, which is dst+1 cycles.
                        r_shift_v    <= 1'b1;
                        r_shift_cnt  <= r_ir_dst;
                        r_shift_last <= w_last;
                        r_state      <= S_SHIFTING;
                    end else if (w_pass_end) begin
                        if (w_loop_more) begin
                            r_pc    <= '0;
                            r_state <= S_FETCH;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else begin
                        r_state <= S_FETCH;
                    end
                end

                S_SHIFTING: begin
                    if (r_shift_cnt == 8'd0) begin
                        r_shift_v <= 1'b0;
                        if (w_pass_end) begin
                            if (w_loop_more) begin
                                r_pc    <= '0;
                                r_state <= S_FETCH;
                            end else begin
                                r_state <= S_DRAIN;
                            end
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end else begin
                        r_shift_cnt <= r_shift_cnt - 8'd1;
                    end
                end

                S_DRAIN: begin
                    // busy stays high through the done cycle. IDLE clears
                    // busy one cycle later.
                    if ((r_wb & c_WB_BODY) == '0) begin
                        r_done  <= 1'b1;
                        r_pc    <= '0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.im_full = w_full;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.inst_v  = r_inst_v;
    assign bus.inst    = r_inst;
    assign bus.rden    = r_rden;
    assign bus.wben    = r_wb[WB_LAT-1];
    assign bus.shift_v = r_shift_v;

endmodule
`default_nettype wire

// File: tb/tb_inst_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_seq
// Description : Directed self-checking bench for inst_seq. Each run starts
//               the sequencer and records a per-cycle bitmask of every
//               control output. Cycle 1 is the first cycle after the edge
//               that samples start. The masks are compared against
//               hand-derived constants.
// Revision    : 1.0  initial release
// ============================================================================
module tb_inst_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] loop_cnt;

    always #5 clk = ~clk;

    inst_seq_if #(.INST_WIDTH(32)) bus_if ();

    inst_seq dut (
        .clk      (clk),
        .rst      (rst),
`ifdef INST_SEQ_LOOP_EN
        .loop_cnt (loop_cnt),
`endif
        .bus      (bus_if.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Per-run capture
    logic [63:0] m_iv, m_rd, m_wb, m_sv, m_dn, m_bz;
    int          c_iv, c_rd, c_wb, c_dn;
    logic [31:0] q_inst [$];
    logic [31:0] a_inst [64];

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_reset();
        rst             = 1'b1;
        bus_if.im_we    = 1'b0;
        bus_if.im_wdata = '0;
        bus_if.start    = 1'b0;
        loop_cnt        = 8'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic load(input logic [31:0] w);
        bus_if.im_we    = 1'b1;
        bus_if.im_wdata = w;
        @(posedge clk);
        #1 bus_if.im_we = 1'b0;
    endtask

    // Pulse start (optionally together with a load), then record ncyc
    // cycles. restart_at pulses start again during that cycle, which the
    // DUT must ignore.
    task automatic run(input int ncyc, input int restart_at,
                       input bit extra_ld, input logic [31:0] extra_w);
        m_iv = '0; m_rd = '0; m_wb = '0; m_sv = '0; m_dn = '0; m_bz = '0;
        c_iv = 0; c_rd = 0; c_wb = 0; c_dn = 0;
        q_inst.delete();
        bus_if.start = 1'b1;
        if (extra_ld) begin
            bus_if.im_we    = 1'b1;
            bus_if.im_wdata = extra_w;
        end
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        bus_if.im_we = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (bus_if.inst_v) begin
                c_iv++;
                q_inst.push_back(bus_if.inst);
            end
            if (bus_if.rden) c_rd++;
            if (bus_if.wben) c_wb++;
            if (bus_if.done) c_dn++;
            if (k < 64) begin
                m_iv[k]   = bus_if.inst_v;
                m_rd[k]   = bus_if.rden;
                m_wb[k]   = bus_if.wben;
                m_sv[k]   = bus_if.shift_v;
                m_dn[k]   = bus_if.done;
                m_bz[k]   = bus_if.busy;
                a_inst[k] = bus_if.inst;
            end
            bus_if.start = (k == restart_at);
        end
        @(posedge clk);
        #1 bus_if.start = 1'b0;
    endtask

    function automatic logic [63:0] outs_vec();
        return {25'd0, bus_if.inst_v, bus_if.rden, bus_if.wben, bus_if.shift_v,
                bus_if.busy, bus_if.done, bus_if.im_full, bus_if.inst};
    endfunction

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        @(negedge clk);
        check("reset_outputs", outs_vec(), 64'd0);
        @(posedge clk);
        #1;

        // ---------------- empty program: done only ----------------
        run(4, 0, 1'b0, 32'd0);
        check("empty_done", m_dn, 64'h2);
        check("empty_busy", m_bz, 64'h0);
        check("empty_iv",   64'(c_iv), 64'd0);

        // ---------------- three ALU instructions ----------------
        do_reset();
        load(32'h0202_0110);
        load(32'h0202_0111);
        load(32'h0202_0112);
        run(20, 5, 1'b0, 32'd0);
        check("alu3_inst_v", m_iv, 64'h54);
        check("alu3_rden",   m_rd, 64'hA8);
        check("alu3_wben",   m_wb, 64'hA80);
        check("alu3_done",   m_dn, 64'h1000);
        check("alu3_busy",   m_bz, 64'h1FFE);
        check("alu3_shift",  m_sv, 64'h0);
        check("alu3_inst0",  64'(q_inst[0]), 64'h0202_0110);
        check("alu3_inst2",  64'(q_inst[2]), 64'h0202_0112);

        // ---------------- RD, SHIFT dst=3, RD ----------------
        do_reset();
        load(32'h0100_0520);
        load(32'h0300_0003);
        load(32'h0100_0621);
        run(20, 0, 1'b0, 32'd0);
        check("shift_inst_v", m_iv, 64'h404);
        check("shift_rden",   m_rd, 64'h808);
        check("shift_v",      m_sv, 64'h1E0);
        check("shift_wben",   m_wb, 64'h0);
        check("shift_done",   m_dn, 64'h1000);
        check("shift_hold",   64'(a_inst[6]), 64'h0100_0520);
        check("shift_inst1",  64'(q_inst[1]), 64'h0100_0621);

        // ---------------- full instruction memory ----------------
        do_reset();
        for (int i = 0; i < 63; i++) load(32'h0100_0000 | 32'(i));
        check("full_at_63", 64'(bus_if.im_full), 64'd0);
        load(32'h0100_003F);
        check("full_at_64", 64'(bus_if.im_full), 64'd1);
        load(32'h0200_00AA);
        check("full_after_65", 64'(bus_if.im_full), 64'd1);
        run(140, 0, 1'b0, 32'd0);
        check("full_iv_count",   64'(c_iv), 64'd64);
        check("full_rd_count",   64'(c_rd), 64'd64);
        check("full_wb_count",   64'(c_wb), 64'd0);
        check("full_done_count", 64'(c_dn), 64'd1);
        check("full_last_inst",  64'(q_inst[q_inst.size()-1]), 64'h0100_003F);

        // ---------------- early END ----------------
        do_reset();
        load(32'h0200_0001);
        load(32'hFF00_0000);
        load(32'h0200_0002);
        run(16, 0, 1'b0, 32'd0);
        check("end_inst_v", m_iv, 64'h4);
        check("end_wben",   m_wb, 64'h80);
        check("end_done",   m_dn, 64'h100);
        check("end_busy",   m_bz, 64'h1FE);

        // ---------------- load and start in the same cycle ----------------
        do_reset();
        load(32'h0200_0007);
        run(16, 0, 1'b1, 32'h0100_0008);
        check("ldst_inst_v", m_iv, 64'h14);
        check("ldst_inst1",  64'(q_inst[1]), 64'h0100_0008);
        check("ldst_rden",   m_rd, 64'h28);
        check("ldst_wben",   m_wb, 64'h80);
        check("ldst_done",   m_dn, 64'h100);

        // ---------------- reset in the middle of a run ----------------
        do_reset();
        load(32'h0200_0001);
        load(32'h0200_0002);
        load(32'h0200_0003);
        bus_if.start = 1'b1;
        @(posedge clk);
        #1 bus_if.start = 1'b0;          // cycle 1
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;                   // cycle 4, two after first inst_v
        @(posedge clk);
        #1 rst = 1'b0;                   // cycle 5
        @(negedge clk);
        check("abort_outputs", outs_vec(), 64'd0);
        c_wb = 0;
        c_iv = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus_if.wben)   c_wb++;
            if (bus_if.inst_v) c_iv++;
        end
        @(posedge clk);
        #1;
        check("abort_no_wben",  64'(c_wb), 64'd0);
        check("abort_no_issue", 64'(c_iv), 64'd0);
        load(32'h0200_000A);
        run(16, 0, 1'b0, 32'd0);
        check("rerun_inst_v", m_iv, 64'h4);
        check("rerun_wben",   m_wb, 64'h80);
        check("rerun_done",   m_dn, 64'h100);

`ifdef INST_SEQ_LOOP_EN
        // ---------------- three passes of one ALU ----------------
        do_reset();
        load(32'h0200_0005);
        loop_cnt = 8'd2;
        run(20, 0, 1'b0, 32'd0);
        loop_cnt = 8'd0;
        check("loop_inst_v",     m_iv, 64'h54);
        check("loop_wben",       m_wb, 64'hA80);
        check("loop_done",       m_dn, 64'h1000);
        check("loop_done_count", 64'(c_dn), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
